// File: rtl/palette_dbuf_pkg.sv
// palette_pkg: shared types and helpers for the double-buffered palette.
//   state_t        controller states (INIT / IDLE / COPY)
//   rgb_t          unpacked colour, channels right-aligned in 5-bit fields
//   pack_rgb       {r,g,b} -> packed entry for a given channel width
//   unpack_rgb     packed entry -> rgb_t for a given channel width
//   scale_default  pick entry k of a 16 x 12-bit default table and rescale it
package palette_pkg;

   typedef enum logic [1:0] {INIT, IDLE, COPY} state_t;

   typedef struct packed {
      logic [4:0] r;
      logic [4:0] g;
      logic [4:0] b;
   } rgb_t;

   // Sixteen 4-bit-per-channel defaults, entry k at bits [k*12 +: 12].
   localparam logic [16*12-1:0] DEFAULT_PAL_STD = {
      12'h444, 12'h088, 12'h808, 12'h880, 12'h008, 12'h080, 12'h800, 12'h888,
      12'hFFF, 12'h1FF, 12'hF1F, 12'hFF1, 12'h11F, 12'h1F1, 12'hF11, 12'h000};

   function automatic logic [14:0] pack_rgb(input logic [4:0] r, input logic [4:0] g,
                                            input logic [4:0] b, input int cb);
      return (15'(r) << (2*cb)) | (15'(g) << cb) | 15'(b);
   endfunction

   function automatic rgb_t unpack_rgb(input logic [14:0] e, input int cb);
      rgb_t        c;
      logic [14:0] m;
      m   = (15'(1) << cb) - 15'(1);
      c.r = 5'((e >> (2*cb)) & m);
      c.g = 5'((e >> cb) & m);
      c.b = 5'(e & m);
      return c;
   endfunction

   // Output bit j (counted from the MSB) takes source bit 3-(j%4). For cb<=4
   // that is plain MSB truncation; for cb=5 the top source bit is replicated
   // into the new LSB so full-scale stays full-scale.
   function automatic logic [14:0] scale_default(input logic [16*12-1:0] pal,
                                                 input int k, input int cb);
      logic [11:0] e;
      logic [3:0]  c4;
      logic [4:0]  ch [3];
      e = pal[k*12 +: 12];
      for (int c = 0; c < 3; c++) begin
         c4    = e[(2-c)*4 +: 4];
         ch[c] = '0;
         for (int j = 0; j < 5; j++)
            if (j < cb) ch[c][cb-1-j] = c4[3-(j%4)];
      end
      return pack_rgb(ch[0], ch[1], ch[2], cb);
   endfunction

endpackage

// File: rtl/palette_dbuf_if.sv
// palette_dbuf_if: host register window plus video lookup bundle.
//   addr/wrdata/wren/rddata  byte-wide host access to the back bank
//   swap_req/vsync           bank-exchange request and its timing strobe
//   palidx/pal_r/g/b         video lookup (registered colour out)
//   busy/swap_pending        controller status
// master = host/video source, slave = palette_dbuf.
interface palette_dbuf_if #(
   parameter int IDX_W = 6,
   parameter int CB    = 4
);
   logic [IDX_W:0]   addr;
   logic [7:0]       wrdata;
   logic             wren;
   logic [7:0]       rddata;
   logic             swap_req;
   logic             vsync;
   logic [IDX_W-1:0] palidx;
   logic [CB-1:0]    pal_r;
   logic [CB-1:0]    pal_g;
   logic [CB-1:0]    pal_b;
   logic             busy;
   logic             swap_pending;

   modport master (
      output addr, wrdata, wren, swap_req, vsync, palidx,
      input  rddata, pal_r, pal_g, pal_b, busy, swap_pending
   );

   modport slave (
      input  addr, wrdata, wren, swap_req, vsync, palidx,
      output rddata, pal_r, pal_g, pal_b, busy, swap_pending
   );
endinterface

// File: rtl/palette_dbuf_bank.sv
// palette_bank: NUM_ENTRIES x EW register-array RAM.
//   clk                     write clock
//   we/waddr/wdata          synchronous write port
//   raddr_a/rdata_a         asynchronous read (host read-back / copy source)
//   raddr_b/rdata_b         asynchronous read (video lookup)
// No reset: contents are established by the owning controller.
module palette_bank #(
   parameter int NUM_ENTRIES = 64,
   parameter int EW          = 12,
   parameter int AW          = $clog2(NUM_ENTRIES)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [EW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [EW-1:0] rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [EW-1:0] rdata_b
);
   logic [EW-1:0] mem [NUM_ENTRIES];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/palette_dbuf.sv
// palette_dbuf: double-buffered video palette.
//   clk, reset   system clock, synchronous active-high reset
//   bus (slave)  host byte window onto the back bank, swap control,
//                registered video lookup from the front bank, status.
// Host writes stage the low byte; the high-byte write commits the entry.
// A pending swap is taken on vsync; the controller then copies the new front
// into the new back so editing resumes from what is on screen. After reset
// both banks are filled from DEFAULT_PAL (repeating every 16 entries).
module palette_dbuf
   import palette_pkg::*;
#(
   parameter int               IDX_W       = 6,
   parameter int               CB          = 4,
   parameter logic [16*12-1:0] DEFAULT_PAL = DEFAULT_PAL_STD
) (
   input  logic           clk,
   input  logic           reset,
   palette_dbuf_if.slave  bus
);
   localparam int NUM_ENTRIES = 2**IDX_W;
   localparam int EW          = 3*CB;

   state_t           state, state_n;
   logic [IDX_W-1:0] i;
   logic             front_sel;
   logic [7:0]       stage;
   logic             swap_pending;
   logic             busy;
   logic             last;

   logic [1:0]                 we;
   logic [1:0][IDX_W-1:0]      waddr, raddr_a;
   logic [1:0][EW-1:0]         wdata, rd_a, rd_b;
   logic [15:0][EW-1:0]        dflt;

   logic [IDX_W-1:0] entry;
   logic             idle, commit, stage_ld, do_swap;
   logic [EW-1:0]    host_ent, front_a, front_v, back_a;
   logic [15:0]      back_word;
   logic [3:0]       dsel;
   rgb_t             fv;
   logic [CB-1:0]    pal_r, pal_g, pal_b;

   // ---- default table, resolved at elaboration ----
   for (genvar k = 0; k < 16; k++) begin : g_dflt
      assign dflt[k] = EW'(scale_default(DEFAULT_PAL, k, CB));
   end

   assign entry    = bus.addr[IDX_W:1];
   assign idle     = (state == IDLE);
   assign last     = (i == IDX_W'(NUM_ENTRIES-1));
   assign commit   = bus.wren &  bus.addr[0] & idle;
   assign stage_ld = bus.wren & ~bus.addr[0] & idle;
   assign do_swap  = idle & swap_pending & bus.vsync;
   assign host_ent = EW'({bus.wrdata, stage});
   assign dsel     = 4'(i);

   // Bank roles follow front_sel; everything below uses the pre-swap value,
   // so a commit in the swap cycle lands in the bank about to become front.
   assign front_a  = rd_a[front_sel];
   assign front_v  = rd_b[front_sel];
   assign back_a   = rd_a[~front_sel];

   // ---- FSM: state register ----
   always_ff @(posedge clk)
      if (reset) state <= INIT;
      else       state <= state_n;

   // ---- FSM: next state ----
   always_comb begin
      state_n = state;
      unique case (state)
         INIT:    if (last)    state_n = IDLE;
         IDLE:    if (do_swap) state_n = COPY;
         COPY:    if (last)    state_n = IDLE;
         default:              state_n = INIT;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb busy = (state != IDLE);

   // ---- sequencing state ----
   // i sits at 0 in IDLE and wraps back to 0 after the last entry, so every
   // INIT/COPY pass starts at entry 0 without an explicit clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         i            <= '0;
         front_sel    <= 1'b0;
         stage        <= '0;
         swap_pending <= 1'b0;
      end else begin
         i            <= busy ? i + 1'b1 : '0;
         if (do_swap)  front_sel <= ~front_sel;
         if (stage_ld) stage     <= bus.wrdata;
         swap_pending <= bus.swap_req | (swap_pending & ~do_swap);
      end
   end

   // ---- bank port steering ----
   // Only the front bank's host/copy port needs the copy counter; the back
   // bank's port keeps serving host read-back.
   always_comb begin
      for (int k = 0; k < 2; k++)
         raddr_a[k] = (state == COPY && k == int'(front_sel)) ? i : entry;
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         we[k]    = 1'b0;
         waddr[k] = entry;
         wdata[k] = host_ent;
         unique case (state)
            INIT: begin
               we[k]    = 1'b1;
               waddr[k] = i;
               wdata[k] = dflt[dsel];
            end
            COPY: begin
               we[k]    = (k != int'(front_sel));
               waddr[k] = i;
               wdata[k] = front_a;
            end
            default: we[k] = commit & (k != int'(front_sel));
         endcase
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_bank
      palette_bank #(.NUM_ENTRIES(NUM_ENTRIES), .EW(EW)) u_bank (
         .clk     (clk),
         .we      (we[k]),
         .waddr   (waddr[k]),
         .wdata   (wdata[k]),
         .raddr_a (raddr_a[k]),
         .rdata_a (rd_a[k]),
         .raddr_b (bus.palidx),
         .rdata_b (rd_b[k])
      );
   end

   // ---- host read-back ----
   assign back_word  = 16'(back_a);
   assign bus.rddata = bus.addr[0] ? back_word[15:8] : back_word[7:0];

   // ---- video lookup, blanked while the banks are being rewritten ----
   assign fv = unpack_rgb(15'(front_v), CB);

   always_ff @(posedge clk) begin
      if (reset || busy) begin
         pal_r <= '0;
         pal_g <= '0;
         pal_b <= '0;
      end else begin
         pal_r <= CB'(fv.r);
         pal_g <= CB'(fv.g);
         pal_b <= CB'(fv.b);
      end
   end

   assign bus.pal_r        = pal_r;
   assign bus.pal_g        = pal_g;
   assign bus.pal_b        = pal_b;
   assign bus.busy         = busy;
   assign bus.swap_pending = swap_pending;
endmodule
